raster_tile_sched: RTL and testbench

RASTER_TILE_SCHED -- requirements
Module: raster_tile_sched

---
 rtl/raster_tile_sched_pkg.sv | 33 +++
 rtl/raster_tile_fifo.sv | 49 ++++
 rtl/raster_tile_sched.sv | 137 +++++++++++++
 tb/tb_raster_tile_sched.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_tile_sched_pkg.sv
// rtl/raster_tile_sched_pkg.sv - tile entry, DCR and state types shared by the raster tile scheduler
package VX_raster_types;

  localparam int RASTER_TILE_ENTRY_SIZE = 8;

  typedef struct packed {
    logic [15:0] tile_x;
    logic [15:0] tile_y;
    logic [31:0] pbuf_offs;
  } raster_tile_t;

  typedef struct packed {
    logic [31:0] tbuf_addr;
    logic [31:0] tile_count;
    logic [15:0] dst_width;
    logic [15:0] dst_height;
  } raster_dcrs_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  function automatic raster_tile_t decode_tile(input logic [63:0] data);
    raster_tile_t t;
    t.tile_x    = data[15:0];
    t.tile_y    = data[31:16];
    t.pbuf_offs = data[63:32];
    return t;
  endfunction

endpackage

// File: rtl/raster_tile_fifo.sv
// rtl/raster_tile_fifo.sv - synchronous tile-entry FIFO; head is registered storage, visible the cycle after push
module raster_tile_fifo
  import VX_raster_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  raster_tile_t             push_data,
  input  logic                     pop,
  output raster_tile_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  raster_tile_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == ($clog2(DEPTH) + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/raster_tile_sched.sv
// rtl/raster_tile_sched.sv - fetches tile entries from memory and deals them round-robin to rasterizer slices
// Optional clipping of out-of-surface tiles: RASTER_TILE_CLIP_EN
module raster_tile_sched
  import VX_raster_types::*;
#(
  parameter int NUM_SLICES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  raster_dcrs_t          dcrs,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_req_valid,
  output logic [31:0]           mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_rsp_valid,
  input  logic [63:0]           mem_rsp_data,
  output logic                  mem_rsp_ready,
  output logic [NUM_SLICES-1:0] slice_valid,
  output raster_tile_t          slice_tile,
  input  logic [NUM_SLICES-1:0] slice_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  sched_state_t  state;
  raster_dcrs_t  dcrs_q;
  logic [31:0]   req_idx;
  logic [31:0]   retire_cnt;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant_idx;
  logic          grant_found;
  logic          fifo_empty;
  logic          fifo_full;
  logic          req_fire;
  logic          rsp_push;
  logic          head_dispatch;
  logic          head_discard;
  logic          head_pop;
  logic          unused_sig;
  raster_tile_t  head;

  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign mem_rsp_ready = 1'b1;
  // Credits: in-flight reads plus buffered entries never exceed the FIFO, so responses need no backpressure.
  assign mem_req_valid = (state == RUN) && (req_idx < dcrs_q.tile_count) &&
                         (({1'b0, outstanding} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH));
  assign mem_req_addr  = dcrs_q.tbuf_addr + 32'(req_idx * 32'(RASTER_TILE_ENTRY_SIZE));
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign rsp_push      = mem_rsp_valid && (state == RUN) && (outstanding != '0);

`ifdef RASTER_TILE_CLIP_EN
  assign head_discard = (state == RUN) && !fifo_empty &&
                        ((head.tile_x >= dcrs_q.dst_width) || (head.tile_y >= dcrs_q.dst_height));
  assign unused_sig   = fifo_full;
`else
  assign head_discard = 1'b0;
  assign unused_sig   = ^{fifo_full, dcrs_q.dst_width, dcrs_q.dst_height};
`endif

  assign head_dispatch = (state == RUN) && !fifo_empty && !head_discard && grant_found;
  assign head_pop      = head_dispatch || head_discard;
  assign slice_tile    = fifo_empty ? '0 : head;

  // Descending offset scan so the ready slice closest to rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_SLICES - 1; i >= 0; i--) begin
      if (slice_ready[(int'(rr_ptr) + i) % NUM_SLICES]) begin
        grant_found = 1'b1;
        grant_idx   = PW'((int'(rr_ptr) + i) % NUM_SLICES);
      end
    end
  end

  always_comb begin
    slice_valid = '0;
    if (head_dispatch) slice_valid[grant_idx] = 1'b1;
  end

  raster_tile_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rsp_push),
    .push_data (decode_tile(mem_rsp_data)),
    .pop       (head_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      dcrs_q      <= '0;
      req_idx     <= '0;
      retire_cnt  <= '0;
      outstanding <= '0;
      rr_ptr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dcrs_q     <= dcrs;
            req_idx    <= '0;
            retire_cnt <= '0;
            state      <= (dcrs.tile_count == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (req_fire) req_idx <= req_idx + 32'd1;
          if (head_pop) begin
            retire_cnt <= retire_cnt + 32'd1;
            if (retire_cnt + 32'd1 == dcrs_q.tile_count) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (req_fire && !rsp_push)      outstanding <= outstanding + 1'b1;
      else if (!req_fire && rsp_push) outstanding <= outstanding - 1'b1;

      if (head_dispatch)
        rr_ptr <= (grant_idx == PW'(NUM_SLICES - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_raster_tile_sched.sv
// tb/tb_raster_tile_sched.sv - scoreboard bench for raster_tile_sched
module tb_raster_tile_sched;
  import VX_raster_types::*;

  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  raster_dcrs_t  dcrs = '0;
  logic          busy, done;
  logic          mem_req_valid;
  logic [31:0]   mem_req_addr;
  logic          mem_req_ready = 1'b1;
  logic          mem_rsp_valid = 1'b0;
  logic [63:0]   mem_rsp_data = '0;
  logic          mem_rsp_ready;
  logic [NS-1:0] slice_valid;
  raster_tile_t  slice_tile;
  logic [NS-1:0] slice_ready = '1;

  raster_tile_sched #(.NUM_SLICES(NS), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .dcrs          (dcrs),
    .busy          (busy),
    .done          (done),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_ready (mem_rsp_ready),
    .slice_valid   (slice_valid),
    .slice_tile    (slice_tile),
    .slice_ready   (slice_ready)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_addr_q[$];
  logic [63:0] rsp_q[$];
  logic [63:0] exp_tile_q[$];
  int          exp_slice_q[$];
  bit          rsp_en = 1'b1;
  bit          inject = 1'b0;
  logic [63:0] inject_data = '0;
  int          pending = 0;
  int          cyc = 0, req_cnt = 0, disp_cnt = 0, done_seen = 0;
  int          last_disp_cyc = 0, done_cyc = 0, idle_cyc = 0;
  int          mon_idx;
  bit          req_hs;
  logic        prev_busy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rsp_word(input logic [15:0] x, input logic [15:0] y, input logic [31:0] p);
    return {p, y, x};
  endfunction

  function automatic logic [63:0] tile_word(input logic [15:0] x, input logic [15:0] y, input logic [31:0] p);
    return {x, y, p};
  endfunction

  task automatic add_tile(input int slice, input logic [15:0] x, input logic [15:0] y,
                          input logic [31:0] p, input bit dispatched);
    rsp_q.push_back(rsp_word(x, y, p));
    if (dispatched) begin
      exp_slice_q.push_back(slice);
      exp_tile_q.push_back(tile_word(x, y, p));
    end
  endtask

  // Monitor, scoreboard and in-order memory responder.
  always @(negedge clk) begin
    cyc++;
    req_hs = mem_req_valid && mem_req_ready;
    if (req_hs) begin
      req_cnt++;
      if (exp_addr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL req_unexpected: got addr 0x%0h, expected no request", mem_req_addr);
      end else begin
        check("req_addr", mem_req_addr, exp_addr_q.pop_front());
      end
    end
    if (|(slice_valid & slice_ready)) begin
      mon_idx = 0;
      for (int i = 0; i < NS; i++) if (slice_valid[i]) mon_idx = i;
      check("slice_onehot", 64'($countones(slice_valid)), 64'd1);
      if (exp_slice_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL disp_unexpected: got slice %0d tile 0x%0h, expected no dispatch", mon_idx, slice_tile);
      end else begin
        check("disp_slice", 64'(mon_idx), 64'(exp_slice_q.pop_front()));
        check("disp_tile", slice_tile, exp_tile_q.pop_front());
      end
      disp_cnt++;
      last_disp_cyc = cyc;
    end
    if (done) begin
      done_seen++;
      done_cyc = cyc;
    end
    if (prev_busy && !busy) idle_cyc = cyc;
    prev_busy = busy;

    mem_rsp_valid = 1'b0;
    if (inject) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = inject_data;
      inject        = 1'b0;
    end else if (rsp_en && pending > 0 && rsp_q.size() > 0) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = rsp_q.pop_front();
      pending--;
    end
    if (req_hs) pending++;
  end

  task automatic do_reset();
    @(posedge clk);
    #1 reset_n = 1'b0;
    exp_addr_q.delete(); rsp_q.delete(); exp_tile_q.delete(); exp_slice_q.delete();
    pending = 0; inject = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_req_addr", mem_req_addr, 0);
    check("rst_rsp_ready", mem_rsp_ready, 1);
    check("rst_slice_valid", slice_valid, 0);
    check("rst_slice_tile", slice_tile, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    req_cnt = 0; disp_cnt = 0; done_seen = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int maxc);
    int c = 0;
    while (!done && c < maxc) begin
      @(negedge clk);
      c++;
    end
    check({name, "_done_seen"}, done, 1);
    @(posedge clk);
    #1;
    check({name, "_busy_low"}, busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic frame_end(input string name, input int ndisp);
    check({name, "_addr_left"}, 64'(exp_addr_q.size()), 0);
    check({name, "_disp_left"}, 64'(exp_slice_q.size()), 0);
    check({name, "_disp_cnt"}, 64'(disp_cnt), 64'(ndisp));
    check({name, "_done_pulses"}, 64'(done_seen), 1);
  endtask

  initial begin
    // Zero tiles: done the cycle after start, idle the cycle after that, no request.
    do_reset();
    dcrs = '{tbuf_addr: 32'h5000, tile_count: 32'd0, dst_width: 16'd64, dst_height: 16'd64};
    pulse_start();
    check("zero_done", done, 1);
    check("zero_busy", busy, 1);
    check("zero_req_valid", mem_req_valid, 0);
    @(posedge clk);
    #1;
    check("zero_done_clear", done, 0);
    check("zero_busy_low", busy, 0);
    @(posedge clk);
    #1;
    check("zero_done_pulses", 64'(done_seen), 1);

    // Three tiles, all slices ready.
    do_reset();
    dcrs = '{tbuf_addr: 32'h1000, tile_count: 32'd3, dst_width: 16'd64, dst_height: 16'd64};
    exp_addr_q = '{32'h1000, 32'h1008, 32'h1010};
    for (int k = 0; k < 3; k++) add_tile(k, 16'(k + 1), 16'(k + 8), 32'hA000_0000 + 32'(k), 1'b1);
    pulse_start();
    check("t1_first_req_valid", mem_req_valid, 1);
    check("t1_first_req_addr", mem_req_addr, 32'h1000);
    wait_done("t1", 200);
    frame_end("t1", 3);
    check("t1_done_after_last", 64'(done_cyc), 64'(last_disp_cyc + 1));
    check("t1_idle_after_done", 64'(idle_cyc), 64'(done_cyc + 1));

    // Response stall: credits cap outstanding reads at FIFO_DEPTH.
    do_reset();
    rsp_en = 1'b0;
    dcrs = '{tbuf_addr: 32'h2000, tile_count: 32'd10, dst_width: 16'd64, dst_height: 16'd64};
    for (int k = 0; k < 10; k++) begin
      exp_addr_q.push_back(32'h2000 + 32'(8 * k));
      add_tile(k % 4, 16'(k), 16'(2 * k), 32'h100 + 32'(k), 1'b1);
    end
    pulse_start();
    repeat (12) @(posedge clk);
    #1;
    check("t2_stall_req_cnt", 64'(req_cnt), 4);
    check("t2_stall_req_valid", mem_req_valid, 0);
    check("t2_stall_rsp_ready", mem_rsp_ready, 1);
    rsp_en = 1'b1;
    wait_done("t2", 300);
    frame_end("t2", 10);
    check("t2_req_cnt", 64'(req_cnt), 10);

    // Sparse ready, address wrap, and address hold under request backpressure.
    do_reset();
    slice_ready   = 4'b1010;
    mem_req_ready = 1'b0;
    dcrs = '{tbuf_addr: 32'hFFFF_FFF0, tile_count: 32'd4, dst_width: 16'd64, dst_height: 16'd64};
    exp_addr_q = '{32'hFFFF_FFF0, 32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0008};
    add_tile(1, 16'd3, 16'd4, 32'h11, 1'b1);
    add_tile(3, 16'd5, 16'd6, 32'h22, 1'b1);
    add_tile(1, 16'd7, 16'd8, 32'h33, 1'b1);
    add_tile(3, 16'd9, 16'd10, 32'h44, 1'b1);
    pulse_start();
    check("t3_hold_valid0", mem_req_valid, 1);
    check("t3_hold_addr0", mem_req_addr, 32'hFFFF_FFF0);
    @(posedge clk);
    #1;
    check("t3_hold_valid1", mem_req_valid, 1);
    check("t3_hold_addr1", mem_req_addr, 32'hFFFF_FFF0);
    mem_req_ready = 1'b1;
    wait_done("t3", 200);
    frame_end("t3", 4);
    slice_ready = '1;

    // Mid-frame reset abort, late response dropped, then a one-tile frame.
    do_reset();
    dcrs = '{tbuf_addr: 32'h6000, tile_count: 32'd5, dst_width: 16'd64, dst_height: 16'd64};
    for (int k = 0; k < 5; k++) exp_addr_q.push_back(32'h6000 + 32'(8 * k));
    add_tile(0, 16'd1, 16'd1, 32'h1, 1'b1);
    add_tile(1, 16'd2, 16'd2, 32'h2, 1'b1);
    pulse_start();
    begin
      int c = 0;
      while (disp_cnt < 2 && c < 100) begin
        @(posedge clk);
        c++;
      end
    end
    @(posedge clk);
    #1;
    check("t4_two_dispatched", 64'(disp_cnt), 2);
    check("t4_busy_before_abort", busy, 1);
    check("t4_no_done_before_abort", 64'(done_seen), 0);
    do_reset();
    @(posedge clk);
    #1;
    inject_data = rsp_word(16'h77, 16'h77, 32'hDEAD_BEEF);
    inject = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t4_idle_after_abort", busy, 0);
    check("t4_abort_no_done", 64'(done_seen), 0);
    dcrs = '{tbuf_addr: 32'h3000, tile_count: 32'd1, dst_width: 16'd64, dst_height: 16'd64};
    exp_addr_q = '{32'h3000};
    add_tile(0, 16'd9, 16'd9, 32'h99, 1'b1);
    pulse_start();
    wait_done("t4", 200);
    frame_end("t4", 1);

    // Entry outside the surface: dropped when clipping is built in.
    do_reset();
    dcrs = '{tbuf_addr: 32'h4000, tile_count: 32'd2, dst_width: 16'd64, dst_height: 16'd64};
    exp_addr_q = '{32'h4000, 32'h4008};
    add_tile(0, 16'd0, 16'd5, 32'h50, 1'b1);
`ifdef RASTER_TILE_CLIP_EN
    add_tile(1, 16'd64, 16'd5, 32'h51, 1'b0);
    pulse_start();
    wait_done("t5", 200);
    frame_end("t5", 1);
`else
    add_tile(1, 16'd64, 16'd5, 32'h51, 1'b1);
    pulse_start();
    wait_done("t5", 200);
    frame_end("t5", 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end, expected completion");
    $fatal(1);
  end

endmodule
